// File: rtl/triangulo_if.sv
// Sample bus for the triangulo point-in-triangle tester: one query per cycle in,
// one inside/edge-sign verdict per cycle out, no backpressure.
interface triangulo_if;
  logic        in_valid;
  logic [11:0] pt1X;
  logic [11:0] pt1Y;
  logic [11:0] pt2X;
  logic [11:0] pt2Y;
  logic [11:0] pt3X;
  logic [11:0] pt3Y;
  logic [11:0] ptX;
  logic [11:0] ptY;
  logic        out_valid;
  logic        dentro;
  logic [2:0]  sinal;
  logic        degen;

  modport master (
    output in_valid, pt1X, pt1Y, pt2X, pt2Y, pt3X, pt3Y, ptX, ptY,
    input  out_valid, dentro, sinal, degen
  );

  modport slave (
    input  in_valid, pt1X, pt1Y, pt2X, pt2Y, pt3X, pt3Y, ptX, ptY,
    output out_valid, dentro, sinal, degen
  );
endinterface

// File: rtl/triangulo.sv
// Three-stage pipelined point-in-triangle test using edge functions.
// Define TRIANGULO_DEGEN_EN to add zero-area detection (degen flag, dentro forced low).
module triangulo (
  input  logic       clk,
  input  logic       rst_n,
  triangulo_if.slave bus
);

  typedef logic signed [12:0] diff_t;
  typedef logic signed [26:0] edge_t;

  function automatic diff_t sub13(input logic [11:0] a, input logic [11:0] b);
    return $signed({1'b0, a}) - $signed({1'b0, b});
  endfunction

  // E = px*ay - ax*py on pre-formed differences; 26-bit products cannot overflow
  function automatic edge_t edge_fn(input diff_t px, input diff_t ay,
                                    input diff_t ax, input diff_t py);
    logic signed [25:0] m0;
    logic signed [25:0] m1;
    m0 = px * ay;
    m1 = ax * py;
    return 27'(m0) - 27'(m1);
  endfunction

  logic  v1_r;
  diff_t d12x_r, d12y_r, d23x_r, d23y_r, d31x_r, d31y_r;
  diff_t p2x_r, p2y_r, p3x_r, p3y_r, p1x_r, p1y_r;

  logic  v2_r;
  edge_t e12_r, e23_r, e31_r;

  logic       out_valid_r;
  logic       dentro_r;
  logic [2:0] sinal_r;

  logic [2:0] ge_s;
  logic [2:0] le_s;
  logic       dentro_s;

`ifdef TRIANGULO_DEGEN_EN
  logic area_zero_r;
  logic degen_r;
`endif

  // Stage 1: edge vectors (a-b) and query offsets (p-b), b being each edge's end vertex
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r   <= 1'b0;
      d12x_r <= 13'sd0;
      d12y_r <= 13'sd0;
      d23x_r <= 13'sd0;
      d23y_r <= 13'sd0;
      d31x_r <= 13'sd0;
      d31y_r <= 13'sd0;
      p2x_r  <= 13'sd0;
      p2y_r  <= 13'sd0;
      p3x_r  <= 13'sd0;
      p3y_r  <= 13'sd0;
      p1x_r  <= 13'sd0;
      p1y_r  <= 13'sd0;
    end else begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        d12x_r <= sub13(bus.pt1X, bus.pt2X);
        d12y_r <= sub13(bus.pt1Y, bus.pt2Y);
        d23x_r <= sub13(bus.pt2X, bus.pt3X);
        d23y_r <= sub13(bus.pt2Y, bus.pt3Y);
        d31x_r <= sub13(bus.pt3X, bus.pt1X);
        d31y_r <= sub13(bus.pt3Y, bus.pt1Y);
        p2x_r  <= sub13(bus.ptX, bus.pt2X);
        p2y_r  <= sub13(bus.ptY, bus.pt2Y);
        p3x_r  <= sub13(bus.ptX, bus.pt3X);
        p3y_r  <= sub13(bus.ptY, bus.pt3Y);
        p1x_r  <= sub13(bus.ptX, bus.pt1X);
        p1y_r  <= sub13(bus.ptY, bus.pt1Y);
      end
    end
  end

  // Stage 2: the three edge functions (and the area term when enabled)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r  <= 1'b0;
      e12_r <= 27'sd0;
      e23_r <= 27'sd0;
      e31_r <= 27'sd0;
`ifdef TRIANGULO_DEGEN_EN
      area_zero_r <= 1'b0;
`endif
    end else begin
      v2_r <= v1_r;
      if (v1_r) begin
        e12_r <= edge_fn(p2x_r, d12y_r, d12x_r, p2y_r);
        e23_r <= edge_fn(p3x_r, d23y_r, d23x_r, p3y_r);
        e31_r <= edge_fn(p1x_r, d31y_r, d31x_r, p1y_r);
`ifdef TRIANGULO_DEGEN_EN
        // E(pt1,pt2,pt3) rewritten in terms of the stored (1-2) and (2-3) vectors
        area_zero_r <= (edge_fn(d12x_r, d23y_r, d23x_r, d12y_r) == 27'sd0);
`endif
      end
    end
  end

  // Sign classification; accepting both all->=0 and all-<=0 makes winding irrelevant
  always_comb begin
    ge_s     = {~e31_r[26], ~e23_r[26], ~e12_r[26]};
    le_s     = {e31_r[26] | (e31_r == 27'sd0),
                e23_r[26] | (e23_r == 27'sd0),
                e12_r[26] | (e12_r == 27'sd0)};
    dentro_s = (&ge_s) | (&le_s);
`ifdef TRIANGULO_DEGEN_EN
    if (area_zero_r) begin
      dentro_s = 1'b0;
    end else begin
      dentro_s = (&ge_s) | (&le_s);
    end
`endif
  end

  // Stage 3: output flags, held between valid samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      dentro_r    <= 1'b0;
      sinal_r     <= 3'b000;
`ifdef TRIANGULO_DEGEN_EN
      degen_r     <= 1'b0;
`endif
    end else begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        dentro_r <= dentro_s;
        sinal_r  <= ge_s;
`ifdef TRIANGULO_DEGEN_EN
        degen_r  <= area_zero_r;
`endif
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.dentro    = dentro_r;
  assign bus.sinal     = sinal_r;
`ifdef TRIANGULO_DEGEN_EN
  assign bus.degen     = degen_r;
`else
  assign bus.degen     = 1'b0;
`endif

endmodule

// File: tb/tb_triangulo.sv
// Directed bench for triangulo: hand-computed edge-function cases, streaming,
// mid-flight reset and extreme coordinates (degenerate case follows TRIANGULO_DEGEN_EN).
module tb_triangulo;

  logic clk = 1'b0;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  triangulo_if bus ();

  triangulo dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

`ifdef TRIANGULO_DEGEN_EN
  localparam logic DEG_ON = 1'b1;
`else
  localparam logic DEG_ON = 1'b0;
`endif

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_tri(input logic [11:0] ax, input logic [11:0] ay,
                         input logic [11:0] bx, input logic [11:0] by,
                         input logic [11:0] cx, input logic [11:0] cy);
    bus.pt1X = ax; bus.pt1Y = ay;
    bus.pt2X = bx; bus.pt2Y = by;
    bus.pt3X = cx; bus.pt3Y = cy;
  endtask

  task automatic drive(input logic v, input logic [11:0] x, input logic [11:0] y);
    bus.in_valid = v;
    bus.ptX      = x;
    bus.ptY      = y;
  endtask

  // One isolated sample; result must appear on the third negedge after the capturing edge
  task automatic pulse(input string tag, input logic [11:0] x, input logic [11:0] y,
                       input logic exp_d, input logic [2:0] exp_s, input logic exp_g);
    @(negedge clk); drive(1'b1, x, y);
    @(negedge clk); drive(1'b0, 12'd0, 12'd0);
    @(negedge clk);
    check_eq({tag, "/early"}, bus.out_valid, 1'b0);
    @(negedge clk);
    check_eq({tag, "/ovalid"}, bus.out_valid, 1'b1);
    check_eq({tag, "/dentro"}, bus.dentro, exp_d);
    check_eq({tag, "/sinal"}, bus.sinal, exp_s);
    check_eq({tag, "/degen"}, bus.degen, exp_g);
    @(negedge clk);
    check_eq({tag, "/drop"}, bus.out_valid, 1'b0);
    check_eq({tag, "/hold"}, bus.dentro, exp_d);
  endtask

  logic        vpat [0:7];
  logic [11:0] sx   [0:7];
  logic [11:0] sy   [0:7];
  logic        sd   [0:7];
  logic [2:0]  ss   [0:7];
  logic        last_d;
  logic [2:0]  last_s;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 12'd0, 12'd0);
    set_tri(12'd13, 12'd13, 12'd32, 12'd10, 12'd16, 12'd30);
    #1;
    check_eq("rst/ovalid", bus.out_valid, 1'b0);
    check_eq("rst/dentro", bus.dentro, 1'b0);
    check_eq("rst/sinal", bus.sinal, 3'b000);
    check_eq("rst/degen", bus.degen, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    pulse("p18_18", 12'd18, 12'd18, 1'b1, 3'b111, 1'b0);
    pulse("p15_15", 12'd15, 12'd15, 1'b1, 3'b111, 1'b0);
    pulse("p9_15",  12'd9,  12'd15, 1'b0, 3'b011, 1'b0);
    pulse("p18_10", 12'd18, 12'd10, 1'b0, 3'b110, 1'b0);
    pulse("vtx2",   12'd32, 12'd10, 1'b1, 3'b111, 1'b0);

    // Clockwise winding: all three E negative
    set_tri(12'd13, 12'd13, 12'd16, 12'd30, 12'd32, 12'd10);
    pulse("cw18_18", 12'd18, 12'd18, 1'b1, 3'b000, 1'b0);
    set_tri(12'd13, 12'd13, 12'd32, 12'd10, 12'd16, 12'd30);

    // Streaming with a gap: slot pattern 1 1 0 1 1 1 0 0
    vpat = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    sx   = '{12'd18, 12'd15, 12'd0, 12'd9,  12'd18, 12'd32, 12'd0, 12'd0};
    sy   = '{12'd18, 12'd15, 12'd0, 12'd15, 12'd10, 12'd10, 12'd0, 12'd0};
    sd   = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    ss   = '{3'b111, 3'b111, 3'b000, 3'b011, 3'b110, 3'b111, 3'b000, 3'b000};
    last_d = 1'b1;
    last_s = 3'b000;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        check_eq($sformatf("strm%0d/ovalid", k - 3), bus.out_valid, vpat[k - 3]);
        if (vpat[k - 3]) begin
          check_eq($sformatf("strm%0d/dentro", k - 3), bus.dentro, sd[k - 3]);
          check_eq($sformatf("strm%0d/sinal", k - 3), bus.sinal, ss[k - 3]);
          last_d = sd[k - 3];
          last_s = ss[k - 3];
        end else begin
          check_eq($sformatf("strm%0d/hold_d", k - 3), bus.dentro, last_d);
          check_eq($sformatf("strm%0d/hold_s", k - 3), bus.sinal, last_s);
        end
      end
      if (k < 8) drive(vpat[k], sx[k], sy[k]);
      else       drive(1'b0, 12'd0, 12'd0);
    end

    // Reset with two samples in flight; held outputs are 1/111 beforehand
    @(negedge clk); drive(1'b1, 12'd18, 12'd18);
    @(negedge clk); drive(1'b1, 12'd15, 12'd15);
    @(negedge clk); drive(1'b0, 12'd0, 12'd0);
    rst_n = 1'b0;
    #1;
    check_eq("midrst/ovalid", bus.out_valid, 1'b0);
    check_eq("midrst/dentro", bus.dentro, 1'b0);
    check_eq("midrst/sinal", bus.sinal, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("postrst%0d/ovalid", k), bus.out_valid, 1'b0);
    end
    pulse("postrst", 12'd18, 12'd10, 1'b0, 3'b110, 1'b0);

    // Extreme coordinates: E = +16769025, -16769025, +16769025
    set_tri(12'd0, 12'd0, 12'd4095, 12'd0, 12'd0, 12'd4095);
    pulse("ext_far", 12'd4095, 12'd4095, 1'b0, 3'b101, 1'b0);
    pulse("ext_org", 12'd0, 12'd0, 1'b1, 3'b111, 1'b0);

    // Collinear vertices: all E = 0, area = 0
    set_tri(12'd0, 12'd0, 12'd5, 12'd5, 12'd10, 12'd10);
    pulse("collin", 12'd5, 12'd5, ~DEG_ON, 3'b111, DEG_ON);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/triangulo.md
TRIANGULO -- requirements
Module: triangulo

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, with all state clearing on rst_n low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 in_valid  input  1  qualifies the input sample on the current clk edge.
REQ-005 pt1X, pt1Y, pt2X, pt2Y, pt3X, pt3Y  input  12 each  unsigned triangle vertex coordinates.
REQ-006 ptX, ptY  input  12 each  unsigned coordinates of the query point.
REQ-007 out_valid  output  1  marks the cycle in which dentro/sinal are valid for one sample.
REQ-008 dentro  output  1  1 = query point inside or on the triangle boundary.
REQ-009 sinal  output  3  per-edge non-negative flags: bit0 edge 1-2, bit1 edge 2-3, bit2 edge 3-1.
REQ-010 degen  output  1  degenerate (zero-area) triangle flag; see Configuration.

Function
REQ-011 Edge function SHALL be E(a,b,p) = (pX-bX)*(aY-bY) - (aX-bX)*(pY-bY), computed for (a,b) = (pt1,pt2), (pt2,pt3), (pt3,pt1).
REQ-012 Coordinates SHALL be zero-extended; differences SHALL be 13-bit signed; products SHALL be 26-bit signed; E SHALL be 27-bit signed, with no overflow or truncation anywhere.
REQ-013 sinal[i] SHALL be 1 when the corresponding E >= 0.
REQ-014 dentro SHALL be 1 when all three E >= 0 or all three E <= 0, so either vertex winding works and edges and vertices count as inside.
REQ-015 The block SHALL be fully pipelined with 3 register stages: inputs, differences, products/E, output flags.
REQ-016 Latency SHALL be 3 clk cycles from the in_valid edge to out_valid, and the block SHALL accept one sample per cycle with no backpressure.
REQ-017 out_valid SHALL follow in_valid delayed by exactly 3 cycles.
REQ-018 dentro, sinal and degen SHALL hold their last value while out_valid = 0.
REQ-019 Samples taken with in_valid = 0 SHALL NOT produce an out_valid pulse.

Reset
REQ-020 While rst_n = 0, out_valid, dentro, sinal, degen and all pipeline valid bits SHALL be 0.
REQ-021 Reset asserted mid-operation SHALL discard every in-flight sample, and no out_valid SHALL appear for samples accepted before reset.
REQ-022 The first sample accepted after rst_n rises SHALL emerge after exactly 3 cycles.

Configuration
REQ-023 With TRIANGULO_DEGEN_EN defined, the block SHALL compute A = E(pt1,pt2,pt3) in the same pipeline; when A = 0 it SHALL set degen = 1 and force dentro = 0, with sinal unaffected.
REQ-024 Without TRIANGULO_DEGEN_EN, degen SHALL be tied 0, no area logic SHALL be built, and collinear vertices SHALL follow REQ-014 unchanged.

Verification
All scenarios use triangle pt1 = (13,13), pt2 = (32,10), pt3 = (16,30) unless stated.
REQ-025 pt = (18,18), in_valid pulse -> 3 cycles later out_valid = 1, dentro = 1, sinal = 3'b111 (E = 110, 152, 70).
REQ-026 pt = (15,15) -> dentro = 1; pt = (9,15) -> dentro = 0, sinal = 3'b011; pt = (18,10) -> dentro = 0, sinal[0] = 0.
REQ-027 pt = (32,10), the vertex -> dentro = 1 (E = 0, 0, 332); repeat with pt2 and pt3 swapped (clockwise winding) -> dentro = 1 for (18,18).
REQ-028 Back-to-back in_valid for 5 points -> 5 consecutive out_valid cycles in order; in_valid gaps reproduced 3 cycles later.
REQ-029 rst_n low while 2 samples are in flight -> outputs 0 immediately, no out_valid for those samples; after release, a new sample emerges at +3.
REQ-030 Extremes pt1 = (0,0), pt2 = (4095,0), pt3 = (0,4095), pt = (4095,4095) -> dentro = 0 with no overflow. With TRIANGULO_DEGEN_EN, collinear vertices (0,0), (5,5), (10,10) and pt = (5,5) -> degen = 1, dentro = 0.
